// File: rtl/booth_sequencer.sv
// booth_sequencer: control FSM sequencing a radix-2 Booth multiplier datapath (load, init, shift-add, capture)
module booth_sequencer #(
    parameter int NUM_ITER = 16,
    parameter int Width_CO = 5,
    parameter int TIMEOUT  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic                done_ack,
    input  logic                count,
    output logic                ready,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic                load,
    output logic                enable_A,
    output logic                enable_B,
    output logic                load_PP,
    output logic                enable_PP,
    output logic                load_P,
    output logic [Width_CO-1:0] iter_cnt
);
    localparam int WW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, LOAD, INIT, ITER, SYNC, CAPTURE, DONE} state_t;
    state_t              state_q, state_d;
    logic [Width_CO-1:0] iter_q, iter_d;
    logic [WW-1:0]       wait_q, wait_d;
    logic                error_q, error_d;
    logic                rst_q;
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        wait_d  = wait_q;
        error_d = error_q;
        case (state_q)
            IDLE:    state_d = (start && !abort && !rst_q) ? LOAD : IDLE;
            LOAD:    state_d = INIT;
            INIT: begin
                iter_d  = '0;
                state_d = ITER;
            end
            ITER: begin
                state_d = (iter_q == Width_CO'(NUM_ITER - 1)) ? SYNC : ITER;
                iter_d  = (iter_q == Width_CO'(NUM_ITER - 1)) ? iter_q : iter_q + 1'b1;
            end
            SYNC: begin
                wait_d = wait_q + 1'b1;
                if (count)
                    state_d = CAPTURE;
                else if (wait_q == WW'(TIMEOUT - 1)) begin
                    state_d = DONE;
                    error_d = 1'b1;
                end
            end
            CAPTURE: begin
                error_d = 1'b0;
                state_d = DONE;
            end
            DONE: begin
                if (done_ack) begin
                    state_d = IDLE;
                    error_d = 1'b0;
                    iter_d  = '0;
                    wait_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        // abort wins over every transition except from IDLE, where it only blocks start
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            iter_d  = '0;
            wait_d  = '0;
            error_d = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            iter_q  <= '0;
            wait_q  <= '0;
            error_q <= 1'b0;
            rst_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            wait_q  <= wait_d;
            error_q <= error_d;
            rst_q   <= 1'b0;
        end
    end
    // rst_q keeps ready low for the first IDLE cycle that still follows a reset edge
    assign ready     = state_q == IDLE && !rst_q;
    assign busy      = state_q inside {LOAD, INIT, ITER, SYNC, CAPTURE};
    assign done      = state_q == DONE;
    assign error     = error_q;
    assign load      = state_q == LOAD;
    assign enable_A  = state_q == LOAD;
    assign enable_B  = state_q == LOAD;
    assign load_PP   = state_q == INIT;
    assign enable_PP = state_q == INIT || state_q == ITER;
    assign load_P    = state_q == CAPTURE;
    assign iter_cnt  = iter_q;
endmodule
